cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the single L2/EWB memory port between the L1 instruction cache and the L1 data cache. It presents one request at a time downstream on the `mem_*` handshake and holds the granted request's address and data stable until `mem_resp`. It returns `mem_resp` and `mem_rdata` only to the granted requester. Contested requests alternate round-robin so that neither cache starves.

## Interface
- `LINE_BITS`, default 256: cache line width in bits.
- `ADDR_BITS`, default 32: address width in bits (rv32i_word).
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `i_read`, in, 1: I-cache line read request. Held until `i_resp`.
- `i_address`, in, ADDR_BITS: I-cache line address.
- `i_rdata`, out, LINE_BITS: read line returned to the I-cache.
- `i_resp`, out, 1: one-cycle completion pulse to the I-cache.
- `d_read`, in, 1: D-cache line read request.
- `d_write`, in, 1: D-cache line write request (writeback). Never asserted together with `d_read`.
- `d_address`, in, ADDR_BITS: D-cache line address.
- `d_wdata`, in, LINE_BITS: D-cache writeback line.
- `d_rdata`, out, LINE_BITS: read line returned to the D-cache.
- `d_resp`, out, 1: one-cycle completion pulse to the D-cache.
- `mem_read`, out, 1: downstream read request.
- `mem_write`, out, 1: downstream write request.
- `mem_address`, out, ADDR_BITS: downstream address.
- `mem_wdata`, out, LINE_BITS: downstream write line.
- `mem_rdata`, in, LINE_BITS: downstream read line. Valid when `mem_resp` is high.
- `mem_resp`, in, 1: downstream completion pulse.

## Operation
- States:
  - `IDLE`: no transaction in flight.
  - `GRANT_I`: I-cache transaction in flight.
  - `GRANT_D`: D-cache transaction in flight.
- `rr_last` is a 1-bit register holding the last served requester. Reset value is I, so the D-cache wins the first tie.
- In `IDLE`:
  - `i_req = i_read`; `d_req = d_read | d_write`.
  - Only one request active: grant it.
  - Both active: grant the requester that is not `rr_last`.
  - On a grant, capture address, wdata and direction into holding registers and move to `GRANT_x`.
  - No request: stay in `IDLE`.
- In `GRANT_x`:
  - `mem_read` / `mem_write` are driven from the holding registers, never from the live inputs.
  - `mem_address` and `mem_wdata` are also driven from the holding registers.
  - On `mem_resp`: pulse `x_resp` in the same cycle, update `rr_last := x`, clear the holding request bits, and return to `IDLE`.
- `i_rdata` and `d_rdata` pass `mem_rdata` through combinationally. Only the `resp` pulse qualifies them.
- `x_resp = mem_resp & (state == GRANT_x)`. A `mem_resp` seen in `IDLE` is ignored.
- A requester must drop its request in the cycle after its `resp`. Because the arbiter is in `IDLE` that cycle, the stale request is never re-granted.
- Granted requester drops its request before `mem_resp` (protocol violation):
  - The downstream transaction is not aborted. It is held until `mem_resp`.
  - The resp pulse is still generated and `rr_last` is still updated.
- A request changing address while waiting in `IDLE` is legal. The address is sampled only at grant.

## Timing
- Reset (async assert; sync deassert handled upstream):
  - state = `IDLE`, `rr_last` = I.
  - `mem_read`, `mem_write`, `i_resp`, `d_resp` = 0.
  - `mem_address` and `mem_wdata` = 0.
  - `i_rdata` and `d_rdata` follow `mem_rdata`.
- Reset mid-transaction: the transaction is abandoned and `mem_*` requests drop immediately. Downstream is reset by the same `rst_n`.
- Latency:
  - Request seen in `IDLE` at cycle N → `mem_read`/`mem_write` high at cycle N+1.
  - `mem_resp` at cycle M → `x_resp` at M (combinational).
  - The arbiter is in `IDLE` at M+1. The next grant's `mem_*` request appears no earlier than M+2.
  - Minimum gap between back-to-back downstream transactions: 1 idle cycle.
- `mem_read`/`mem_write` stay high continuously from grant through the `mem_resp` cycle.
- `mem_address` and `mem_wdata` are constant over that interval.
- `mem_read` and `mem_write` are never both high.

## Test plan
- Single I read:
  - Stimulus: `i_read=1`, `i_address=0x0000_1000`; downstream responds after 5 cycles with rdata `0xAA..AA`.
  - Response: `mem_read` high from N+1; `mem_address=0x1000`; one-cycle `i_resp` with `i_rdata=0xAA..AA`; `d_resp` stays 0.
- Single D write:
  - Stimulus: `d_write=1`, `d_address=0x2000`, `d_wdata=0x55..55`.
  - Response: `mem_write=1` with the same address and data, held until `mem_resp`; `d_resp` pulses once.
- Simultaneous requests out of reset:
  - Stimulus: `i_read` and `d_read` both high.
  - Response: D is served first, then I after one idle cycle; exactly one resp per cache.
- Continuous contention for 4 transactions:
  - Stimulus: both caches keep requesting.
  - Response: grant order is D, I, D, I.
- Address stability:
  - Stimulus: change `i_address` from `0x1000` to `0x3000` while `GRANT_I` is in flight.
  - Response: `mem_address` stays `0x1000`.
- Reset mid-operation:
  - Stimulus: assert `rst_n=0` in the middle of a `GRANT_D` read.
  - Response: `mem_read` drops without waiting for the clock. After release, a new `i_read` is granted with `rr_last` = I behaviour (D still wins a tie).

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares the single L2 memory port between the L1 I-cache and D-cache.
// Ties go round-robin, and the granted request is held stable until mem_resp.
module cache_arbiter #(
  parameter int LINE_BITS = 256,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_read,
  input  logic [ADDR_BITS-1:0] i_address,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [ADDR_BITS-1:0] d_address,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_resp
);

  // state   | meaning
  // IDLE    | nothing in flight; arbitrate the live requests
  // GRANT_I | I-cache line read in flight downstream
  // GRANT_D | D-cache line read or writeback in flight downstream
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  state_t                 state_q, state_d;
  logic                   rr_last_q, rr_last_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_BITS-1:0]   mem_address_q, mem_address_d;
  logic [LINE_BITS-1:0]   mem_wdata_q, mem_wdata_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        grant_i = (rr_last_q == RR_D);
        grant_d = (rr_last_q == RR_I);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d       = GRANT_D;
          mem_read_d    = d_read & ~d_write;
          mem_write_d   = d_write;
          mem_address_d = d_address;
          mem_wdata_d   = d_wdata;
        end else if (grant_i) begin
          state_d       = GRANT_I;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = i_address;
          mem_wdata_d   = '0;
        end
      end
      GRANT_I: begin
        if (mem_resp) begin
          state_d     = IDLE;
          rr_last_d   = RR_I;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          state_d     = IDLE;
          rr_last_d   = RR_D;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_last_q     <= RR_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // Read data is shared; only the resp pulse tells a cache the line is its own.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_resp  = mem_resp & (state_q == GRANT_I);
  assign d_resp  = mem_resp & (state_q == GRANT_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter, checked cycle by cycle against a
// transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  localparam int LB = 256;
  localparam int AB = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AB-1:0] i_address = '0;
  logic [LB-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AB-1:0] d_address = '0;
  logic [LB-1:0] d_wdata = '0;
  logic [LB-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AB-1:0] mem_address;
  logic [LB-1:0] mem_wdata;
  logic [LB-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_BITS(LB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs (percent rates) and requester / downstream state.
  int new_rate, chg_rate, viol_rate, spur_rate, fixed_lat;
  bit use_fixed_rd;
  logic [LB-1:0] fixed_rd, rdata_v;
  bit i_pend, d_pend, d_is_wr, i_drop_next, d_drop_next;
  logic [AB-1:0] i_addr_v, d_addr_v;
  logic [LB-1:0] d_wdata_v;
  bit dn_busy;
  int dn_lat;

  // Reference model: what is in flight downstream and who was served last.
  bit m_busy, m_own_d, m_last_d, m_wr;
  logic [AB-1:0] m_addr;
  logic [LB-1:0] m_wdata;

  // Responses as actually observed from the DUT (1 = D-cache, 0 = I-cache).
  bit resp_log[$];
  int i_resp_seen, d_resp_seen;

  task automatic chk_val(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rnd100();
    return int'($urandom_range(99));
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_knobs(input int nr, input int cr, input int vr, input int sr, input int fl);
    new_rate = nr; chg_rate = cr; viol_rate = vr; spur_rate = sr; fixed_lat = fl;
  endtask

  task automatic clear_logs();
    resp_log.delete();
    i_resp_seen = 0;
    d_resp_seen = 0;
  endtask

  task automatic apply_inputs();
    i_read    = i_pend;
    d_read    = d_pend & ~d_is_wr;
    d_write   = d_pend & d_is_wr;
    i_address = i_addr_v;
    d_address = d_addr_v;
    d_wdata   = d_wdata_v;
  endtask

  task automatic drive_caches();
    if (i_drop_next) begin
      i_pend = 0; i_drop_next = 0;
    end else if (!i_pend && !(m_busy && !m_own_d) && rnd100() < new_rate) begin
      i_pend = 1; i_addr_v = $urandom;
    end else if (i_pend && m_busy && !m_own_d && rnd100() < viol_rate) begin
      i_pend = 0;
    end else if (i_pend && rnd100() < chg_rate) begin
      i_addr_v = $urandom;
    end
    if (d_drop_next) begin
      d_pend = 0; d_drop_next = 0;
    end else if (!d_pend && !(m_busy && m_own_d) && rnd100() < new_rate) begin
      d_pend = 1; d_is_wr = 1'($urandom_range(1)); d_addr_v = $urandom; d_wdata_v = rand_line();
    end else if (d_pend && m_busy && m_own_d && rnd100() < viol_rate) begin
      d_pend = 0;
    end else if (d_pend && rnd100() < chg_rate) begin
      d_addr_v = $urandom; d_wdata_v = rand_line();
    end
    apply_inputs();
  endtask

  // Downstream memory: responds a few cycles after it sees a request.
  task automatic drive_mem();
    rdata_v  = use_fixed_rd ? fixed_rd : rand_line();
    mem_resp = 1'b0;
    if (mem_read || mem_write) begin
      if (!dn_busy) begin
        dn_busy = 1;
        dn_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(4));
      end
      if (dn_lat == 0) begin
        mem_resp = 1'b1; dn_busy = 0;
      end else begin
        dn_lat--;
      end
    end else begin
      dn_busy = 0;
      if (rnd100() < spur_rate) mem_resp = 1'b1;
    end
    mem_rdata = rdata_v;
  endtask

  task automatic model_advance();
    if (m_busy) begin
      if (mem_resp) begin
        m_busy   = 0;
        m_last_d = m_own_d;
        if (m_own_d) d_drop_next = 1;
        else         i_drop_next = 1;
      end
    end else if (i_pend || d_pend) begin
      m_own_d = d_pend && (!i_pend || !m_last_d);
      m_busy  = 1;
      if (m_own_d) begin
        m_wr = d_is_wr; m_addr = d_addr_v; m_wdata = d_wdata_v;
      end else begin
        m_wr = 0; m_addr = i_addr_v; m_wdata = '0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk_val("mem_read", LB'(mem_read), LB'(m_busy && !m_wr));
    chk_val("mem_write", LB'(mem_write), LB'(m_busy && m_wr));
    if (m_busy) begin
      chk_val("mem_address", LB'(mem_address), LB'(m_addr));
      if (m_wr) chk_val("mem_wdata", mem_wdata, m_wdata);
    end
    drive_caches();
    drive_mem();
    #1;
    chk_val("i_resp", LB'(i_resp), LB'(mem_resp && m_busy && !m_own_d));
    chk_val("d_resp", LB'(d_resp), LB'(mem_resp && m_busy && m_own_d));
    chk_val("i_rdata", i_rdata, rdata_v);
    chk_val("d_rdata", d_rdata, rdata_v);
    if (i_resp) begin resp_log.push_back(1'b0); i_resp_seen++; end
    if (d_resp) begin resp_log.push_back(1'b1); d_resp_seen++; end
    model_advance();
  endtask

  task automatic clear_state();
    i_pend = 0; d_pend = 0; d_is_wr = 0; i_drop_next = 0; d_drop_next = 0;
    i_addr_v = '0; d_addr_v = '0; d_wdata_v = '0;
    dn_busy = 0; dn_lat = 0;
    m_busy = 0; m_own_d = 0; m_last_d = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    apply_inputs();
    mem_resp = 1'b0;
    clear_logs();
  endtask

  task automatic do_reset();
    logic [LB-1:0] rv;
    rst_n = 1'b0;
    clear_state();
    repeat (2) @(negedge clk);
    rv = rand_line();
    mem_rdata = rv;
    mem_resp  = 1'b1;
    #1;
    chk_val("rst_mem_read", LB'(mem_read), LB'(0));
    chk_val("rst_mem_write", LB'(mem_write), LB'(0));
    chk_val("rst_mem_address", LB'(mem_address), LB'(0));
    chk_val("rst_mem_wdata", mem_wdata, LB'(0));
    chk_val("rst_i_resp", LB'(i_resp), LB'(0));
    chk_val("rst_d_resp", LB'(d_resp), LB'(0));
    chk_val("rst_i_rdata", i_rdata, rv);
    chk_val("rst_d_rdata", d_rdata, rv);
    mem_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    use_fixed_rd = 0;
    fixed_rd = '0;
    set_knobs(0, 0, 0, 0, -1);
    do_reset();

    // Single I read, 0xAA line back after 5 cycles.
    set_knobs(0, 0, 0, 0, 5);
    use_fixed_rd = 1;
    fixed_rd = {(LB/8){8'hAA}};
    i_pend = 1; i_addr_v = 32'h0000_1000;
    repeat (12) step();
    chk_val("single_i_resp_count", LB'(i_resp_seen), LB'(1));
    chk_val("single_i_no_d_resp", LB'(d_resp_seen), LB'(0));
    use_fixed_rd = 0;

    // Single D writeback.
    clear_logs();
    d_pend = 1; d_is_wr = 1; d_addr_v = 32'h0000_2000; d_wdata_v = {(LB/4){4'h5}};
    repeat (12) step();
    chk_val("single_d_resp_count", LB'(d_resp_seen), LB'(1));
    chk_val("single_d_no_i_resp", LB'(i_resp_seen), LB'(0));

    // Simultaneous requests out of reset: D first, then I.
    do_reset();
    set_knobs(0, 0, 0, 0, 3);
    i_pend = 1; i_addr_v = $urandom;
    d_pend = 1; d_is_wr = 0; d_addr_v = $urandom;
    repeat (20) step();
    chk_val("tie_resp_total", LB'(resp_log.size()), LB'(2));
    if (resp_log.size() == 2) begin
      chk_val("tie_first_is_d", LB'(resp_log[0]), LB'(1));
      chk_val("tie_second_is_i", LB'(resp_log[1]), LB'(0));
    end
    chk_val("tie_i_once", LB'(i_resp_seen), LB'(1));
    chk_val("tie_d_once", LB'(d_resp_seen), LB'(1));

    // Continuous contention: D, I, D, I.
    do_reset();
    set_knobs(100, 0, 0, 0, 2);
    i_pend = 1; i_addr_v = $urandom;
    d_pend = 1; d_is_wr = 0; d_addr_v = $urandom;
    repeat (30) step();
    chk_val("rr_at_least_4", LB'(resp_log.size() >= 4), LB'(1));
    if (resp_log.size() >= 4) begin
      for (int k = 0; k < 4; k++)
        chk_val($sformatf("rr_order_%0d", k), LB'(resp_log[k]), LB'((k % 2) == 0));
    end

    // Address stability while GRANT_I is in flight.
    do_reset();
    set_knobs(0, 0, 0, 0, 5);
    i_pend = 1; i_addr_v = 32'h0000_1000;
    repeat (2) step();
    i_addr_v = 32'h0000_3000;
    repeat (2) step();
    chk_val("addr_stable", LB'(mem_address), LB'(32'h0000_1000));
    repeat (8) step();
    chk_val("addr_stable_resp", LB'(i_resp_seen), LB'(1));

    // Randomized traffic with address churn, early drops and stray mem_resp.
    do_reset();
    set_knobs(30, 20, 3, 10, -1);
    repeat (4000) step();

    // Reset in the middle of a D read, then a tie still goes to D.
    do_reset();
    set_knobs(0, 0, 0, 0, 10);
    d_pend = 1; d_is_wr = 0; d_addr_v = $urandom;
    repeat (3) step();
    chk_val("midrst_pre_mem_read", LB'(mem_read), LB'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("midrst_mem_read_async", LB'(mem_read), LB'(0));
    do_reset();
    set_knobs(0, 0, 0, 0, 2);
    i_pend = 1; i_addr_v = $urandom;
    d_pend = 1; d_is_wr = 0; d_addr_v = $urandom;
    repeat (16) step();
    chk_val("midrst_resp_total", LB'(resp_log.size()), LB'(2));
    if (resp_log.size() >= 1) chk_val("midrst_tie_d_first", LB'(resp_log[0]), LB'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
